turn_signal_ctrl: RTL
=====================

# turn_signal_ctrl

Mode controller and sequencer for the tail-light blinker path. It arbitrates between left-turn, right-turn, hazard and brake inputs and divides the system clock into blink steps. It drives the 3-LED left and right banks with the 0/1/2/3-lamp sweep, and exports the current step index to the seven-segment display.

## Interface
- TICK_DIV, 12_500_000: clock cycles per blink step; legal range ≥2.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- left_req  in  1  left-turn request (level).
- right_req  in  1  right-turn request (level).
- hazards  in  1  hazard request (level); highest priority.
- brake  in  1  brake pedal (level).
- left_leds  out  3  left bank; bit0 is the innermost lamp.
- right_leds  out  3  right bank; bit0 is the innermost lamp.
- phase  out  2  current step 0..3, for the seven-segment decoder.
- mode  out  2  current state: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.

## Operation
- States: IDLE, LEFT, RIGHT, HAZARD.
- Request decode, combinational, every cycle:
  - hazards=1 -> HAZARD.
  - Else exactly one of left_req/right_req -> LEFT/RIGHT.
  - Else (none, or both turn requests) -> IDLE.
- Prescaler: counter 0..TICK_DIV-1, held at 0 in IDLE. tick = (count==TICK_DIV-1) and the state is not IDLE. Width is $clog2(TICK_DIV).
- Phase: held at 0 in IDLE. On tick, phase increments modulo 4 (3 -> 0 is the wrap).
- Transitions:
  - From IDLE, if the decoded request is not IDLE: enter it next cycle, with phase=0 and count=0.
  - hazards asserted in LEFT/RIGHT: enter HAZARD next cycle, with phase=0 and count=0. Hazard preempts immediately.
  - Any other change of decoded request (release, left<->right, hazard release) is taken only on a wrap tick. The current sweep always completes.
  - If the decoded request at the wrap tick is IDLE, go to IDLE. Otherwise go to that mode, with phase=0.
- Lamp pattern for phase p: 000, 001, 011, 111 for p=0..3.
- Output mapping, registered from next-state values:
  - LEFT: left_leds=pattern(phase). right_leds=111 if brake, else 000.
  - RIGHT: mirror of LEFT.
  - HAZARD: both banks = pattern(phase). brake is ignored.
  - IDLE: both banks 111 if brake, else 000.
- phase and mode outputs mirror the internal registers.

## Timing
- Reset values: left_leds=000, right_leds=000, phase=0, mode=0 (IDLE), prescaler=0. Reset takes effect immediately and asynchronously, including mid-sweep. After release, the block starts in IDLE on the next edge.
- Request to first visible change: 1 cycle. mode changes and phase=0 is displayed on edge N+1 after the request is seen at edge N.
- Step period: exactly TICK_DIV cycles. Phase 0 is shown for TICK_DIV cycles after entry, then phase 1, and so on.
- A full sweep is 4*TICK_DIV cycles. Back-to-back sweeps in the same mode have no idle gap.
- brake changes reach the LEDs 1 cycle after sampling, in any state, without waiting for a tick.
- Hazard entry resets the prescaler, so the first HAZARD step lasts a full TICK_DIV.
- Hazard release with a turn request still held: the HAZARD sweep completes, then the turn mode starts at phase 0 on the wrap.

## Test plan
- TICK_DIV=4. Reset, then hold left_req=1 -> mode=1. left_leds goes 000,001,011,111, with each value held 4 cycles. It repeats with no gap. right_leds=000 throughout.
- Left active, drop left_req at phase 1 -> the sweep continues through phase 3. At the wrap tick: mode=0 and both banks 000.
- Left active at phase 2, assert hazards -> the next cycle shows mode=3, phase=0 and both banks 000. Both banks then step together with 4-cycle spacing.
- IDLE with brake=1 -> both banks 111. Then right_req=1 -> left_leds=111 and right_leds sweeps. Both turn requests at once -> IDLE with 111/111.
- HAZARD with brake=1 -> brake is ignored and both banks follow the pattern. Release hazards while right_req=1 -> the HAZARD sweep finishes, then mode=2 at phase 0.
- Assert reset_n=0 mid-sweep at phase 3 -> all outputs are 0 within the same cycle, asynchronously. After release with left_req held -> mode=1 two edges later.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_signal_ctrl: tail-light blinker mode arbiter and lamp-sweep sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module turn_signal_ctrl #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazards,
  input  logic       brake,
  output logic [2:0] left_leds,
  output logic [2:0] right_leds,
  output logic [1:0] phase,
  output logic [1:0] mode
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt, w_req;
  logic [1:0]    r_phase, w_phase_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_run;
  logic          w_tick, w_wrap;
  logic [2:0]    r_left_leds, r_right_leds;
  logic [2:0]    w_left_nxt, w_right_nxt, w_brake_bank;

  function automatic logic [2:0] lamp(input logic [1:0] p);
    case (p)
      2'd0:    lamp = 3'b000;
      2'd1:    lamp = 3'b001;
      2'd2:    lamp = 3'b011;
      default: lamp = 3'b111;
    endcase
  endfunction

  // Requests are ignored for the first edge after reset release.
  always_comb begin
    w_req = IDLE;
    if (r_run) begin
      if (hazards)
        w_req = HAZARD;
      else if (left_req ^ right_req)
        w_req = left_req ? LEFT : RIGHT;
    end
  end

  always_comb begin
    w_tick      = (r_count == C_LAST) && (r_state != IDLE);
    w_wrap      = w_tick && (r_phase == 2'd3);
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_req;
        w_phase_nxt = 2'd0;
        w_count_nxt = '0;
      end
      default: begin
        if ((r_state != HAZARD) && (w_req == HAZARD)) begin
          w_state_nxt = HAZARD;
          w_phase_nxt = 2'd0;
          w_count_nxt = '0;
        end else if (w_wrap) begin
          w_state_nxt = w_req;
          w_phase_nxt = 2'd0;
          w_count_nxt = '0;
        end else if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
    endcase
  end

  // LED banks are derived from the next state so they line up with mode/phase.
  always_comb begin
    w_brake_bank = {3{brake}};
    w_left_nxt   = w_brake_bank;
    w_right_nxt  = w_brake_bank;
    case (w_state_nxt)
      LEFT:    w_left_nxt  = lamp(w_phase_nxt);
      RIGHT:   w_right_nxt = lamp(w_phase_nxt);
      HAZARD: begin
        w_left_nxt  = lamp(w_phase_nxt);
        w_right_nxt = lamp(w_phase_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_phase      <= 2'd0;
      r_count      <= '0;
      r_run        <= 1'b0;
      r_left_leds  <= 3'b000;
      r_right_leds <= 3'b000;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_count      <= w_count_nxt;
      r_run        <= 1'b1;
      r_left_leds  <= w_left_nxt;
      r_right_leds <= w_right_nxt;
    end
  end

  assign left_leds  = r_left_leds;
  assign right_leds = r_right_leds;
  assign phase      = r_phase;
  assign mode       = r_state;

endmodule
`default_nettype wire
